// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_pkg;

    localparam int IFU_ADDR_W = 32;
    localparam int IFU_INST_W = 32;

    // Word presented in place of the instruction on a fetch fault.
    localparam logic [IFU_INST_W-1:0] INST_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch: latch pc, read memory, hold {pc, inst} for decode.
// Optional IFU_ALIGN_CHECK_EN: a misaligned pc faults locally without touching memory.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int ADDR_W = IFU_ADDR_W,
    parameter int INST_W = IFU_INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_fault,
    output logic              pc_wen
);

    fetch_state_e state;
    logic         drop;

    // The PC register loads on the same edge decode takes the instruction,
    // so IDLE sees the advanced pc on the following cycle.
    assign pc_wen = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            drop          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_inst      <= '0;
            out_fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // pc is stale on a flush cycle; wait for the reload.
                    if (!flush) begin
                        mem_req_addr <= pc;
`ifdef IFU_ALIGN_CHECK_EN
                        if (pc[1:0] != 2'b00) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_pc    <= pc;
                            out_fault <= 1'b1;
                            out_inst  <= INST_W'(INST_ZERO);
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                        end
`else
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    // An accepted request owes us a response even if flushed,
                    // so swallow it in WAIT rather than leave it to a later fetch.
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        drop          <= flush;
                        state         <= WAIT;
                    end else if (flush) begin
                        mem_req_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (flush || drop) begin
                            drop  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_pc    <= mem_req_addr;
                            out_fault <= mem_rsp_err;
                            out_inst  <= mem_rsp_err ? INST_W'(INST_ZERO) : mem_rsp_data;
                        end
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush || out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: expected {pc, inst, fault} queued at response time, checked at decode.
module tb_ifu_fetch;

    localparam int AW = 32;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] pc = '0;
    logic          flush = 1'b0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid = 1'b0;
    logic [IW-1:0] mem_rsp_data = '0;
    logic          mem_rsp_err = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_inst;
    logic          out_fault;
    logic          pc_wen;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
        logic          fault;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] exp_addr = '0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            lat;

    always #5 clk = ~clk;

    ifu_fetch #(.ADDR_W(AW), .INST_W(IW)) dut (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_fault(out_fault), .pc_wen(pc_wen)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor on the falling edge; all stimulus changes 1 time unit after the rising edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            if (mem_req_valid) chk("req_addr", mem_req_addr, exp_addr);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", out_valid, 1'b0);
                end else begin
                    e = sb[0];
                    chk("out_pc", out_pc, e.pc);
                    chk("out_inst", out_inst, e.inst);
                    chk("out_fault", out_fault, e.fault);
                    if (flush) begin
                        chk("pcwen_flush", pc_wen, 1'b0);
                        void'(sb.pop_front());
                    end else if (out_ready) begin
                        chk("pcwen_accept", pc_wen, 1'b1);
                        void'(sb.pop_front());
                    end else begin
                        chk("pcwen_stall", pc_wen, 1'b0);
                    end
                end
            end else begin
                chk("pcwen_idle", pc_wen, 1'b0);
            end
        end
    end

    task automatic wait_req(output int n);
        n = 0;
        while (!mem_req_valid && n < 20) begin
            cyc();
            n++;
        end
        chk("req_valid", mem_req_valid, 1'b1);
    endtask

    // Drive one fetch from IDLE up to the point the instruction is presented.
    task automatic to_hold(input logic [AW-1:0] a, input logic [IW-1:0] d, input logic err,
                           input int stall, output int n);
        pc = a;
        exp_addr = a;
        mem_req_ready = 1'b0;
        wait_req(n);
        for (int i = 0; i < stall; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data = 32'hbadbad00 + i;
            cyc();
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        chk("req_done", mem_req_valid, 1'b0);
        sb.push_back(exp_t'{a, (err ? 32'h0 : d), err});
        mem_rsp_valid = 1'b1;
        mem_rsp_data = d;
        mem_rsp_err = err;
        cyc();
        mem_rsp_valid = 1'b0;
        mem_rsp_err = 1'b0;
        chk("hold_valid", out_valid, 1'b1);
    endtask

    task automatic release_out(input int stall);
        repeat (stall) cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("out_drop", out_valid, 1'b0);
    endtask

    initial begin
        pc = 32'h8000_0000;
        mem_req_ready = 1'b1;
        repeat (3) cyc();
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_fault", out_fault, 1'b0);
        chk("rst_pc_wen", pc_wen, 1'b0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        rst = 1'b1;

        // First fetch after reset: request next cycle, out_valid after the third edge.
        to_hold(32'h8000_0000, 32'h0000_0413, 1'b0, 0, lat);
        chk("lat_first", lat, 1);
        release_out(0);

        // Request and decode backpressure, with stray responses outside WAIT.
        to_hold(32'h8000_0004, 32'h0010_0093, 1'b0, 5, lat);
        chk("lat_next", lat, 1);
        release_out(4);

        // Access fault.
        to_hold(32'h8000_0008, 32'h1234_5678, 1'b1, 0, lat);
        release_out(1);

        // Flush while the request is pending.
        pc = 32'h8000_000c;
        exp_addr = pc;
        wait_req(lat);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("req_withdrawn", mem_req_valid, 1'b0);

        // Flush in WAIT: the late response must be discarded.
        pc = 32'h8000_0040;
        exp_addr = pc;
        wait_req(lat);
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        pc = 32'h8000_0100;
        for (int i = 0; i < 2; i++) begin
            chk("drop_noreq", mem_req_valid, 1'b0);
            cyc();
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hdead_beef;
        cyc();
        mem_rsp_valid = 1'b0;
        chk("drop_noout", out_valid, 1'b0);
        to_hold(32'h8000_0100, 32'h0000_0013, 1'b0, 0, lat);
        chk("lat_redirect", lat, 1);
        release_out(0);

        // Flush beats a simultaneous accept in HOLD.
        to_hold(32'h8000_0104, 32'h0020_0113, 1'b0, 0, lat);
        out_ready = 1'b1;
        flush = 1'b1;
        cyc();
        out_ready = 1'b0;
        flush = 1'b0;
        chk("flush_hold", out_valid, 1'b0);

`ifdef IFU_ALIGN_CHECK_EN
        begin
            logic saw;
            int   n;
            saw = 1'b0;
            n = 0;
            pc = 32'h8000_0002;
            exp_addr = pc;
            sb.push_back(exp_t'{32'h8000_0002, 32'h0, 1'b1});
            while (!out_valid && n < 20) begin
                saw |= mem_req_valid;
                cyc();
                n++;
            end
            chk("align_noreq", saw, 1'b0);
            chk("align_lat", n, 1);
            release_out(0);
        end
`else
        to_hold(32'h8000_0002, 32'hcafe_0013, 1'b0, 0, lat);
        release_out(0);
`endif

        chk("sb_drained", sb.size(), 0);

        // Asynchronous reset in the middle of a presented instruction.
        to_hold(32'h8000_0300, 32'h0000_0517, 1'b0, 0, lat);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_req_valid", mem_req_valid, 1'b0);
        chk("arst_out_pc", out_pc, 32'h0);
        sb.delete();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
